// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: big-endian loads/stores over a req/ack bus,
// with byte-enable or read-modify-write partial stores, ack timeout and alignment checks.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int USE_BE  = 1,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [31:0]       in_rold,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [31:0]       dm_wdata,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic [1:0]        resp_err
);

   localparam logic [3:0] OP_LW  = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [3:0] OP_SB  = 4'd9;
   localparam logic [3:0] OP_SH  = 4'd10;
   localparam logic [3:0] OP_SWL = 4'd11;
   localparam logic [3:0] OP_SWR = 4'd12;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;

   localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       op_q;
   logic [1:0]       k_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rold_q;
   logic             timeout_hit;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= OP_LWR) || ((op >= OP_SW) && (op <= OP_SWR));
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] k);
      case (op)
         OP_LW, OP_SW:         return k != 2'd0;
         OP_LH, OP_LHU, OP_SH: return k[0];
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic is_partial_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SWR);
   endfunction

   // Big-endian: offset k lives in lane 3-k, and for a 2-bit k that is simply ~k.
   function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] k);
      case (op)
         OP_SB:   return 4'b0001 << (~k);
         OP_SH:   return k[1] ? 4'b0011 : 4'b1100;
         OP_SWL:  return 4'hF >> k;
         OP_SWR:  return 4'hF << (~k);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [1:0] k,
                                              input logic [31:0] wdata);
      logic [4:0] up;
      logic [4:0] dn;
      up = {k, 3'b000};
      dn = {~k, 3'b000};
      case (op)
         OP_SB:   return {24'd0, wdata[7:0]} << dn;
         OP_SH:   return k[1] ? {16'd0, wdata[15:0]} : {wdata[15:0], 16'd0};
         OP_SWL:  return wdata >> up;
         OP_SWR:  return wdata << dn;
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] k,
                                               input logic [31:0] rdata, input logic [31:0] rold);
      logic [4:0]         up;
      logic [4:0]         dn;
      logic [7:0]         byte_v;
      logic [15:0]        half_v;
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      up     = {k, 3'b000};
      dn     = {~k, 3'b000};
      byte_v = 8'(rdata >> dn);
      half_v = k[1] ? rdata[15:0] : rdata[31:16];
      byte_s = signed'(byte_v);
      half_s = signed'(half_v);
      case (op)
         OP_LB:   return 32'(byte_s);
         OP_LBU:  return {24'd0, byte_v};
         OP_LH:   return 32'(half_s);
         OP_LHU:  return {16'd0, half_v};
         OP_LWL:  return (rdata << up) | (rold & ~(32'hFFFF_FFFF << up));
         OP_LWR:  return (rdata >> dn) | (rold & ~(32'hFFFF_FFFF >> dn));
         default: return rdata;
      endcase
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] base, input logic [31:0] data,
                                               input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = be[i] ? data[8*i +: 8] : base[8*i +: 8];
      end
      return m;
   endfunction

   assign in_ready    = (state == IDLE);
   assign timeout_hit = (wait_cnt == CNT_LAST);

   // Request operands are plain data; they only matter once a request is in flight.
   always_ff @(posedge CLK) begin
      if (in_valid && (state == IDLE)) begin
         op_q    <= in_op;
         k_q     <= in_addr[1:0];
         wdata_q <= in_wdata;
         rold_q  <= in_rold;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         dm_req     <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_be      <= 4'h0;
         dm_wdata   <= 32'd0;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_err   <= ERR_OK;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dm_addr   <= {in_addr[ADDR_W-1:2], 2'b00};
                  resp_data <= 32'd0;
                  resp_err  <= ERR_OK;
                  wait_cnt  <= '0;
                  if (!op_legal(in_op)) begin
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_ILLEGAL;
                     state      <= RESP;
                  end else if (is_misaligned(in_op, in_addr[1:0])) begin
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_ALIGN;
                     state      <= RESP;
                  end else if ((USE_BE == 0) && is_partial_store(in_op)) begin
                     dm_req <= 1'b1;
                     dm_we  <= 1'b0;
                     dm_be  <= 4'hF;
                     state  <= RMW_RD;
                  end else begin
                     dm_req <= 1'b1;
                     dm_we  <= in_op[3];
                     dm_be  <= in_op[3] ? store_be(in_op, in_addr[1:0]) : 4'hF;
                     if (in_op[3]) begin
                        dm_wdata <= store_data(in_op, in_addr[1:0], in_wdata);
                     end
                     state  <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (dm_ack) begin
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  if (!op_q[3]) begin
                     resp_data <= load_result(op_q, k_q, dm_rdata, rold_q);
                  end
                  state      <= RESP;
               end else if (timeout_hit) begin
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RMW_RD: begin
               if (dm_ack) begin
                  // The write is prepared here but requested only after a bus-idle cycle.
                  dm_req   <= 1'b0;
                  dm_we    <= 1'b1;
                  dm_be    <= 4'hF;
                  dm_wdata <= merge_bytes(dm_rdata, store_data(op_q, k_q, wdata_q),
                                          store_be(op_q, k_q));
                  state    <= RMW_WR;
               end else if (timeout_hit) begin
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RMW_WR: begin
               if (!dm_req) begin
                  dm_req   <= 1'b1;
                  wait_cnt <= '0;
               end else if (dm_ack) begin
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (timeout_hit) begin
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_TIMEOUT;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-enable instance (a) and an RMW instance (b).
module tb_mem_access_unit;

   typedef struct packed {logic [31:0] d; logic [1:0] e;} resp_t;
   typedef struct packed {logic [31:0] a; logic [3:0] be; logic [31:0] d;} wr_t;

   logic        CLK;
   logic        RESET;
   logic        in_valid_a, in_valid_b;
   logic [3:0]  in_op;
   logic [31:0] in_addr, in_wdata, in_rold;

   logic        in_ready_a, dm_req_a, dm_we_a, dm_ack_a, resp_valid_a;
   logic [31:0] dm_addr_a, dm_wdata_a, resp_data_a;
   logic [3:0]  dm_be_a;
   logic [1:0]  resp_err_a;
   logic        in_ready_b, dm_req_b, dm_we_b, dm_ack_b, resp_valid_b;
   logic [31:0] dm_addr_b, dm_wdata_b, resp_data_b;
   logic [3:0]  dm_be_b;
   logic [1:0]  resp_err_b;

   logic [31:0] mem_a, mem_b;
   logic        ack_en_a, ack_en_b, ack_force_a;

   int n_checks = 0;
   int n_fail   = 0;

   resp_t q_resp_a[$];
   resp_t q_resp_b[$];
   wr_t   q_wr_a[$];
   wr_t   q_wr_b[$];

   assign dm_ack_a = (dm_req_a & ack_en_a) | ack_force_a;
   assign dm_ack_b = dm_req_b & ack_en_b;

   mem_access_unit #(.ADDR_W(32), .USE_BE(1), .TIMEOUT(15)) dut_a (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_op(in_op), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rold(in_rold),
      .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_be(dm_be_a),
      .dm_wdata(dm_wdata_a), .dm_ack(dm_ack_a), .dm_rdata(mem_a),
      .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_err(resp_err_a)
   );

   mem_access_unit #(.ADDR_W(32), .USE_BE(0), .TIMEOUT(15)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rold(in_rold),
      .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_be(dm_be_b),
      .dm_wdata(dm_wdata_b), .dm_ack(dm_ack_b), .dm_rdata(mem_b),
      .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_err(resp_err_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: responses, completed writes and read-cycle byte enables.
   always @(negedge CLK) begin
      resp_t r;
      wr_t   w;
      if (resp_valid_a) begin
         if (q_resp_a.size() == 0) check("resp_a_unexpected", 1, 0);
         else begin
            r = q_resp_a.pop_front();
            check("resp_a", {resp_data_a, resp_err_a}, {r.d, r.e});
         end
      end
      if (resp_valid_b) begin
         if (q_resp_b.size() == 0) check("resp_b_unexpected", 1, 0);
         else begin
            r = q_resp_b.pop_front();
            check("resp_b", {resp_data_b, resp_err_b}, {r.d, r.e});
         end
      end
      if (dm_req_a && dm_ack_a && dm_we_a) begin
         if (q_wr_a.size() == 0) check("wr_a_unexpected", 1, 0);
         else begin
            w = q_wr_a.pop_front();
            check("wr_a_addr", dm_addr_a, w.a);
            check("wr_a_be_data", {dm_be_a, dm_wdata_a}, {w.be, w.d});
         end
      end
      if (dm_req_b && dm_ack_b && dm_we_b) begin
         if (q_wr_b.size() == 0) check("wr_b_unexpected", 1, 0);
         else begin
            w = q_wr_b.pop_front();
            check("wr_b_addr", dm_addr_b, w.a);
            check("wr_b_be_data", {dm_be_b, dm_wdata_b}, {w.be, w.d});
         end
      end
      if (dm_req_a && !dm_we_a) check("rd_a_be", dm_be_a, 4'hF);
      if (dm_req_b && !dm_we_b) check("rd_b_be", dm_be_b, 4'hF);
   end

   // Issue one request; lat = accept edge to first cycle resp_valid is seen, reqs = cycles with dm_req high.
   task automatic run(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] ro, output int lat, output int reqs);
      int n;
      n = 0;
      @(negedge CLK);
      while (!(sel ? in_ready_b : in_ready_a)) begin
         @(negedge CLK);
         n++;
         if (n > 50) begin
            check("in_ready_wait_expired", 1, 0);
            break;
         end
      end
      in_op = op; in_addr = addr; in_wdata = wd; in_rold = ro;
      if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      @(posedge CLK);
      #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      lat  = 1;
      reqs = 0;
      forever begin
         @(negedge CLK);
         if (sel ? dm_req_b : dm_req_a) reqs++;
         if (sel ? resp_valid_b : resp_valid_a) break;
         lat++;
         if (lat > 60) begin
            check("resp_wait_expired", 1, 0);
            break;
         end
      end
   endtask

   task automatic push_wr(input bit sel, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
      if (sel) q_wr_b.push_back('{a: a, be: be, d: d});
      else     q_wr_a.push_back('{a: a, be: be, d: d});
   endtask

   task automatic do_op(input string name, input bit sel, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] ro,
                        input logic [31:0] exp_d, input logic [1:0] exp_e,
                        input int exp_lat, input int exp_reqs);
      int lat, reqs;
      if (sel) q_resp_b.push_back('{d: exp_d, e: exp_e});
      else     q_resp_a.push_back('{d: exp_d, e: exp_e});
      run(sel, op, addr, wd, ro, lat, reqs);
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_reqs"}, 64'(reqs), 64'(exp_reqs));
   endtask

   initial begin
      RESET = 1'b1;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      in_op = 4'd0; in_addr = 32'd0; in_wdata = 32'd0; in_rold = 32'd0;
      mem_a = 32'd0; mem_b = 32'd0;
      ack_en_a = 1'b1; ack_en_b = 1'b1; ack_force_a = 1'b0;
      #2 RESET = 1'b0;
      #1;
      check("rst_in_ready", in_ready_a, 1);
      check("rst_dm_req", dm_req_a, 0);
      check("rst_dm_we", dm_we_a, 0);
      check("rst_dm_addr", dm_addr_a, 0);
      check("rst_dm_be", dm_be_a, 0);
      check("rst_dm_wdata", dm_wdata_a, 0);
      check("rst_resp_valid", resp_valid_a, 0);
      check("rst_resp_data", resp_data_a, 0);
      check("rst_resp_err", resp_err_a, 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      // Loads, zero-wait memory
      mem_a = 32'h1122_33F4;
      do_op("lb",  0, 4'd1, 32'h1003, 0, 0, 32'hFFFF_FFF4, 2'd0, 2, 1);
      do_op("lbu", 0, 4'd2, 32'h1003, 0, 0, 32'h0000_00F4, 2'd0, 2, 1);
      mem_a = 32'hAABB_CCDD;
      do_op("lwl", 0, 4'd5, 32'h2001, 0, 32'h1122_3344, 32'hBBCC_DD44, 2'd0, 2, 1);
      do_op("lwr", 0, 4'd6, 32'h2001, 0, 32'h1122_3344, 32'h1122_AABB, 2'd0, 2, 1);
      do_op("lh",  0, 4'd3, 32'h2002, 0, 0, 32'hFFFF_CCDD, 2'd0, 2, 1);
      do_op("lhu", 0, 4'd4, 32'h2000, 0, 0, 32'h0000_AABB, 2'd0, 2, 1);
      do_op("lw",  0, 4'd0, 32'h2000, 0, 0, 32'hAABB_CCDD, 2'd0, 2, 1);

      // Byte-enable stores
      push_wr(0, 32'h3000, 4'b1110, 32'h2233_4400);
      do_op("swr_be", 0, 4'd12, 32'h3002, 32'h1122_3344, 0, 32'd0, 2'd0, 2, 1);
      push_wr(0, 32'h3000, 4'b0111, 32'h0011_2233);
      do_op("swl_be", 0, 4'd11, 32'h3001, 32'h1122_3344, 0, 32'd0, 2'd0, 2, 1);
      push_wr(0, 32'h3000, 4'b0010, 32'h0000_AB00);
      do_op("sb_be", 0, 4'd9, 32'h3002, 32'h0000_00AB, 0, 32'd0, 2'd0, 2, 1);
      push_wr(0, 32'h3000, 4'b0011, 32'h0000_3344);
      do_op("sh_be", 0, 4'd10, 32'h3002, 32'h1122_3344, 0, 32'd0, 2'd0, 2, 1);
      push_wr(0, 32'h3004, 4'hF, 32'hCAFE_F00D);
      do_op("sw_be", 0, 4'd8, 32'h3004, 32'hCAFE_F00D, 0, 32'd0, 2'd0, 2, 1);

      // Read-modify-write store
      mem_b = 32'hAABB_CCDD;
      push_wr(1, 32'h3000, 4'hF, 32'h2233_44DD);
      do_op("swr_rmw", 1, 4'd12, 32'h3002, 32'h1122_3344, 0, 32'd0, 2'd0, 4, 2);

      // Errors without a bus cycle
      do_op("sh_misalign", 0, 4'd10, 32'h4001, 32'h1234_5678, 0, 32'd0, 2'd1, 1, 0);
      do_op("lw_misalign", 0, 4'd0, 32'h4002, 0, 0, 32'd0, 2'd1, 1, 0);
      do_op("illegal_op", 0, 4'd7, 32'h4000, 0, 0, 32'd0, 2'd3, 1, 0);

      // Timeout, then a late ack that must be ignored, then a normal load
      ack_en_a = 1'b0;
      do_op("timeout", 0, 4'd0, 32'h6000, 0, 0, 32'd0, 2'd2, 16, 15);
      @(negedge CLK);
      ack_force_a = 1'b1;
      repeat (2) @(negedge CLK);
      ack_force_a = 1'b0;
      ack_en_a = 1'b1;
      mem_a = 32'h1234_5678;
      do_op("lw_after_to", 0, 4'd0, 32'h6004, 0, 0, 32'h1234_5678, 2'd0, 2, 1);

      // Asynchronous reset while the RMW read is stalled
      ack_en_b = 1'b0;
      mem_b = 32'h0102_0304;
      @(negedge CLK);
      in_op = 4'd9; in_addr = 32'h5000; in_wdata = 32'h0000_007F; in_rold = 0;
      in_valid_b = 1'b1;
      @(posedge CLK);
      #1 in_valid_b = 1'b0;
      repeat (3) @(negedge CLK);
      check("pre_rst_req", dm_req_b, 1);
      RESET = 1'b0;
      #1;
      check("mid_rst_req", dm_req_b, 0);
      check("mid_rst_we", dm_we_b, 0);
      check("mid_rst_addr", dm_addr_b, 0);
      check("mid_rst_be", dm_be_b, 0);
      check("mid_rst_wdata", dm_wdata_b, 0);
      check("mid_rst_resp", {resp_valid_b, resp_data_b, resp_err_b}, 0);
      check("mid_rst_in_ready", in_ready_b, 1);
      @(negedge CLK);
      RESET = 1'b1;
      ack_en_b = 1'b1;
      push_wr(0, 32'h5000, 4'b1000, 32'h7F00_0000);
      do_op("sb_after_rst", 0, 4'd9, 32'h5000, 32'h0000_007F, 0, 32'd0, 2'd0, 2, 1);
      push_wr(1, 32'h5000, 4'hF, 32'h7F02_0304);
      do_op("sb_rmw_after_rst", 1, 4'd9, 32'h5000, 32'h0000_007F, 0, 32'd0, 2'd0, 4, 2);

      repeat (5) @(negedge CLK);
      check("pending_resp_a", q_resp_a.size(), 0);
      check("pending_resp_b", q_resp_b.size(), 0);
      check("pending_wr_a", q_wr_a.size(), 0);
      check("pending_wr_b", q_wr_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
